// File: rtl/burst_rr_arbiter.sv
// Round-robin arbiter that locks one requester onto a shared req/ack channel for a whole burst.
// Optional owner-idle timeout is compiled in with BURST_TIMEOUT_EN.
module burst_rr_arbiter #(
    parameter int N       = 4,
    parameter int LEN_W   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [N-1:0]           req_in,
    input  logic [N*LEN_W-1:0]     len_in,
    output logic [N-1:0]           ack_in,
    output logic                   req_out,
    input  logic                   ack_out,
    output logic [$clog2(N)-1:0]   gnt_id,
    output logic                   busy,
    output logic                   abort
);

    localparam int ID_W = $clog2(N);

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t          state_q, state_d;
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [ID_W-1:0] owner_q, owner_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [ID_W-1:0] winner;
    logic [ID_W-1:0] next_ptr;
    logic            abort_now;
    logic            fire;

    // Rotating priority search starting at ptr.
    always_comb begin
        logic found;
        found  = 1'b0;
        winner = ptr_q;
        for (int k = 0; k < N; k++) begin
            if (!found && req_in[(int'(ptr_q) + k) % N]) begin
                found  = 1'b1;
                winner = ID_W'((int'(ptr_q) + k) % N);
            end
        end
    end

    assign next_ptr = (owner_q == ID_W'(N - 1)) ? '0 : owner_q + ID_W'(1);

`ifdef BURST_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    logic [TMO_W-1:0] tmo_q, tmo_d;

    assign abort_now = (state_q == BURST) && (tmo_q == TMO_W'(TIMEOUT));

    always_comb begin
        tmo_d = '0;
        if (state_q == BURST && !abort_now && !req_in[owner_q])
            tmo_d = tmo_q + TMO_W'(1);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) tmo_q <= '0;
        else       tmo_q <= tmo_d;
    end
`else
    logic unused_timeout;

    assign unused_timeout = |TIMEOUT;
    assign abort_now      = 1'b0;
`endif

    // NOTE: every output of this block gets a default before the case so no latch is inferred.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        req_out = 1'b0;
        ack_in  = '0;
        busy    = 1'b0;
        fire    = 1'b0;

        case (state_q)
            IDLE: begin
                if (|req_in) begin
                    owner_d = winner;
                    cnt_d   = len_in[winner*LEN_W +: LEN_W];
                    state_d = BURST;
                end
            end
            BURST: begin
                busy = 1'b1;
                // An aborting burst passes no further beats.
                req_out = req_in[owner_q] && !abort_now;
                fire    = req_out && ack_out;
                if (fire) ack_in[owner_q] = 1'b1;

                if (abort_now) begin
                    state_d = IDLE;
                    ptr_d   = next_ptr;
                end else if (fire) begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - LEN_W'(1);
                    end else begin
                        state_d = IDLE;
                        ptr_d   = next_ptr;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

    assign gnt_id = owner_q;
    assign abort  = abort_now;

endmodule

// File: tb/tb_burst_rr_arbiter.sv
// Directed bench for burst_rr_arbiter: expected beats go into a queue, a negedge monitor
// pops and compares them against every ack_in it observes.
module tb_burst_rr_arbiter;

    localparam int N       = 4;
    localparam int LEN_W   = 4;
    localparam int TIMEOUT = 15;

    logic               clk = 1'b0;
    logic               rstn;
    logic [N-1:0]       req_in;
    logic [N*LEN_W-1:0] len_in;
    logic [N-1:0]       ack_in;
    logic               req_out;
    logic               ack_out;
    logic [1:0]         gnt_id;
    logic               busy;
    logic               abort;

    burst_rr_arbiter #(.N(N), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .req_in  (req_in),
        .len_in  (len_in),
        .ack_in  (ack_in),
        .req_out (req_out),
        .ack_out (ack_out),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .abort   (abort)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cycle;
        logic [N-1:0] ack;
        logic [1:0] id;
    } beat_t;

    beat_t exp_q[$];
    beat_t mon_b;
    int    n_cmp     = 0;
    int    n_fail    = 0;
    int    abort_cnt = 0;
    int    abort_cyc = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every observed beat must match the head of the expected queue.
    always @(negedge clk) begin
        if (abort === 1'b1) begin
            abort_cnt++;
            abort_cyc = cyc;
        end
        if (ack_in !== '0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ack", 32'(ack_in), 32'd0);
            end else begin
                mon_b = exp_q.pop_front();
                check("beat_cycle", 32'(cyc), 32'(mon_b.cycle));
                check("ack_in", 32'(ack_in), 32'(mon_b.ack));
                check("gnt_id_beat", 32'(gnt_id), 32'(mon_b.id));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_beat(input int c, input int id);
        beat_t b;
        b.cycle = c;
        b.ack   = N'(1) << id;
        b.id    = 2'(id);
        exp_q.push_back(b);
    endtask

    task automatic set_len(input int i, input int v);
        len_in[i*LEN_W +: LEN_W] = LEN_W'(v);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ack_in"}, 32'(ack_in), 32'd0);
        check({tag, "_req_out"}, 32'(req_out), 32'd0);
        check({tag, "_gnt_id"}, 32'(gnt_id), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_abort"}, 32'(abort), 32'd0);
    endtask

    task automatic do_reset();
        rstn    = 1'b0;
        req_in  = '0;
        len_in  = '0;
        ack_out = 1'b0;
        tick(2);
        check_idle_outputs("in_reset");
        rstn      = 1'b1;
        abort_cnt = 0;
        abort_cyc = -1;
    endtask

    task automatic check_drained(input string tag);
        tick(2);
        check({tag, "_missing_beats"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int c;

        // Single requester, 4-beat burst, then ptr = 1 decides the next grant.
        do_reset();
        check_idle_outputs("after_reset");
        c = cyc;
        req_in = 4'b0001; set_len(0, 3); ack_out = 1'b1;
        for (int k = 1; k <= 4; k++) expect_beat(c + k, 0);
        tick(1);
        check("t1_busy_on", 32'(busy), 32'd1);
        tick(4);
        check("t1_busy_off", 32'(busy), 32'd0);
        req_in = 4'b0011; set_len(1, 0);
        expect_beat(c + 6, 1);
        tick(2);
        req_in = '0;
        check_drained("t1");

        // All requesting, single-beat bursts, rotation 0,1,2,3,0 with one idle bubble each.
        do_reset();
        c = cyc;
        req_in = 4'b1111; len_in = '0; ack_out = 1'b1;
        for (int k = 0; k < 5; k++) expect_beat(c + 1 + 2 * k, k % 4);
        tick(2);
        check("t2_bubble_busy", 32'(busy), 32'd0);
        check("t2_gnt_hold", 32'(gnt_id), 32'd0);
        tick(8);
        req_in = '0;
        check_drained("t2");

        // Burst lock: owner 2 keeps 6 beats despite req_in[0] and a len change.
        do_reset();
        c = cyc;
        req_in = 4'b0100; set_len(2, 5); set_len(0, 0); ack_out = 1'b1;
        for (int k = 1; k <= 6; k++) expect_beat(c + k, 2);
        expect_beat(c + 8, 0);
        tick(2);
        req_in = 4'b0101; set_len(2, 0);
        tick(5);
        check("t3_idle_busy", 32'(busy), 32'd0);
        check("t3_gnt_hold", 32'(gnt_id), 32'd2);
        tick(2);
        req_in = '0;
        check_drained("t3");

        // Backpressure: ack_out 1,0,0,1,1 over the burst gives beats only when high.
        do_reset();
        c = cyc;
        req_in = 4'b0010; set_len(1, 2); ack_out = 1'b1;
        expect_beat(c + 1, 1); expect_beat(c + 4, 1); expect_beat(c + 5, 1);
        tick(1); ack_out = 1'b1;
        tick(1); ack_out = 1'b0;
        check("t4_req_out_stall", 32'(req_out), 32'd1);
        tick(1); ack_out = 1'b0;
        check("t4_busy_stall", 32'(busy), 32'd1);
        tick(1); ack_out = 1'b1;
        tick(1); ack_out = 1'b1;
        tick(1);
        check("t4_busy_end", 32'(busy), 32'd0);
        req_in = '0;
        check_drained("t4");

        // Owner drops its request after 2 of 8 beats.
        do_reset();
        c = cyc;
        req_in = 4'b0001; set_len(0, 7); ack_out = 1'b1;
        expect_beat(c + 1, 0); expect_beat(c + 2, 0);
        tick(3);
        req_in = '0;
`ifdef BURST_TIMEOUT_EN
        tick(14);
        check("t5_no_early_abort", 32'(abort_cnt), 32'd0);
        check("t5_busy_wait", 32'(busy), 32'd1);
        tick(2);
        check("t5_abort_count", 32'(abort_cnt), 32'd1);
        check("t5_abort_cycle", 32'(abort_cyc), 32'(c + 18));
        check("t5_busy_after", 32'(busy), 32'd0);
        req_in = 4'b0011; set_len(1, 0);
        expect_beat(c + 20, 1);
        tick(2);
        req_in = '0;
`else
        tick(20);
        check("t5_busy_locked", 32'(busy), 32'd1);
        check("t5_no_abort", 32'(abort_cnt), 32'd0);
        check("t5_req_out_low", 32'(req_out), 32'd0);
`endif
        check_drained("t5");

        // Reset during beat 3 of owner 3's 8-beat burst; ptr returns to 0.
        do_reset();
        c = cyc;
        req_in = 4'b0100; set_len(2, 0); set_len(3, 7); ack_out = 1'b1;
        expect_beat(c + 1, 2);
        tick(2);
        req_in = 4'b1000;
        expect_beat(c + 3, 3); expect_beat(c + 4, 3);
        tick(3);
        rstn = 1'b0;
        #1;
        check_idle_outputs("t6_async");
        tick(1);
        rstn = 1'b1;
        req_in = 4'b1001; set_len(0, 0);
        check("t6_gnt_after", 32'(gnt_id), 32'd0);
        expect_beat(c + 7, 0);
        tick(2);
        req_in = '0;
        check("t6_no_abort", 32'(abort_cnt), 32'd0);
        check_drained("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
